// File: rtl/boot_sequencer_pkg.sv
// Shared definitions for the boot sequencer.
//   state_t        : sequencer states (CHK is only reachable with BOOT_CHECKSUM_EN)
//   HDR_LEN        : header length in bytes (little-endian word count)
//   BYTES_PER_WORD : payload bytes packed into each IROM word
package boot_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_HDR0  = 3'd0,
    ST_HDR1  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_CHK   = 3'd3,
    ST_START = 3'd4,
    ST_RUN   = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  localparam int HDR_LEN        = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/boot_sequencer_byte_packer.sv
// byte_packer: assembles little-endian bytes into 32-bit words.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : drop any partial word (byte counter back to 0)
//   in_accept   : a byte is taken this cycle
//   in_data     : the byte
//   byte_cnt    : position of the next byte within the word
//   word_valid  : one-cycle pulse the cycle after the 4th byte is taken
//   word        : assembled word (stable while word_valid is high)
module byte_packer
  import boot_sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_accept,
  input  logic [7:0]            in_data,
  output logic [BYTE_CNT_W-1:0] byte_cnt,
  output logic                  word_valid,
  output logic [31:0]           word
);

  // Bytes shift in from the top, so after four bytes byte 0 sits in [7:0].
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt   <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        byte_cnt <= '0;
      end else if (in_accept) begin
        word       <= {in_data, word[31:8]};
        byte_cnt   <= byte_cnt + 1'b1;
        word_valid <= (byte_cnt == LAST_BYTE);
      end
    end
  end

endmodule

// File: rtl/boot_sequencer.sv
// boot_sequencer: loads a framed byte stream into IROM, then starts the core.
// Frame: 2-byte little-endian word count N, then 4*N payload bytes.
// Optional: define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte
// (state CHK); mismatch goes to ERROR.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   in_valid/in_data/in_ready: byte stream handshake (accept on valid & ready)
//   soft_reboot              : restart loading, honoured in RUN and ERROR
//   setup                    : high whenever the core is not running
//   irom_we/addr/wdata       : IROM word write port
//   pc_first_we/addr         : one-cycle PC load with BOOT_PC
//   core_run                 : high in RUN
//   boot_error               : high in ERROR (sticky until soft_reboot/reset)
module boot_sequencer
  import boot_sequencer_pkg::*;
#(
  parameter int          ADDR_W  = 10,
  parameter logic [31:0] BOOT_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  input  logic              soft_reboot,
  output logic              setup,
  output logic              irom_we,
  output logic [ADDR_W-1:0] irom_addr,
  output logic [31:0]       irom_wdata,
  output logic              pc_first_we,
  output logic [31:0]       pc_first_addr,
  output logic              core_run,
  output logic              boot_error
);

  localparam int          N_W      = 8 * HDR_LEN;
  // One extra bit so a full 2**ADDR_W load ends without the index wrapping.
  localparam int          IDX_W    = ADDR_W + 1;
  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

  state_t           state, state_next;
  logic [7:0]       n_lo_q;
  logic [N_W-1:0]   n_q;
  logic [N_W-1:0]   n_header;
  logic [IDX_W-1:0] idx_q;
  logic             full_q, full_next;
  logic             in_ready_q, ready_next;
  logic             accept;
  logic             last_word;

  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic                  word_valid;
  logic [31:0]           word;

`ifdef BOOT_CHECKSUM_EN
  logic [7:0] csum_q;
`endif

  assign accept    = in_valid & in_ready_q;
  assign n_header  = {in_data, n_lo_q};
  assign last_word = (32'(idx_q) + 32'd1) == 32'(n_q);

  byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state != ST_LOAD),
    .in_accept  (accept && (state == ST_LOAD)),
    .in_data    (in_data),
    .byte_cnt   (byte_cnt),
    .word_valid (word_valid),
    .word       (word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_HDR0;
      n_lo_q     <= '0;
      n_q        <= '0;
      idx_q      <= '0;
      full_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state      <= state_next;
      full_q     <= full_next;
      in_ready_q <= ready_next;
      if (state == ST_HDR0 && accept) n_lo_q <= in_data;
      if (state == ST_HDR1 && accept) n_q    <= n_header;
      if (state != ST_LOAD)   idx_q <= '0;
      else if (word_valid)    idx_q <= idx_q + 1'b1;
    end
  end

`ifdef BOOT_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          csum_q <= '0;
    else if (state == ST_HDR1)           csum_q <= '0;
    else if (state == ST_LOAD && accept) csum_q <= csum_q ^ in_data;
  end
`endif

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    full_next  = 1'b0;
    case (state)
      ST_HDR0: if (accept) state_next = ST_HDR1;
      ST_HDR1: begin
        if (accept) begin
          if (n_header == '0) begin
`ifdef BOOT_CHECKSUM_EN
            state_next = ST_CHK;
`else
            state_next = ST_START;
`endif
          end else if (32'(n_header) > CAPACITY) begin
            state_next = ST_ERROR;
          end else begin
            state_next = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        // Once the final byte is taken, stop accepting while the last
        // word drains to IROM.
        full_next = full_q | (accept && byte_cnt == LAST_BYTE && last_word);
        if (word_valid && last_word) begin
`ifdef BOOT_CHECKSUM_EN
          state_next = ST_CHK;
`else
          state_next = ST_START;
`endif
          full_next  = 1'b0;
        end
      end
`ifdef BOOT_CHECKSUM_EN
      ST_CHK:   if (accept) state_next = (in_data == csum_q) ? ST_START : ST_ERROR;
`endif
      ST_START: state_next = ST_RUN;
      ST_RUN:   if (soft_reboot) state_next = ST_HDR0;
      ST_ERROR: if (soft_reboot) state_next = ST_HDR0;
      default:  state_next = ST_HDR0;
    endcase
    // in_ready is registered so it stays low through reset and rises on the
    // first edge afterwards.
    ready_next = (state_next inside {ST_HDR0, ST_HDR1, ST_CHK}) ||
                 (state_next == ST_LOAD && !full_next);
  end

  assign in_ready      = in_ready_q;
  assign setup         = (state != ST_RUN);
  assign core_run      = (state == ST_RUN);
  assign boot_error    = (state == ST_ERROR);
  assign pc_first_we   = (state == ST_START);
  assign pc_first_addr = BOOT_PC;
  assign irom_we       = word_valid && (state == ST_LOAD);
  assign irom_addr     = idx_q[ADDR_W-1:0];
  assign irom_wdata    = word;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer (ADDR_W=4, BOOT_PC=0). Define
// BOOT_CHECKSUM_EN for both RTL and bench to exercise the checksum build.
module tb_boot_sequencer;

  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              soft_reboot;
  logic              setup;
  logic              irom_we;
  logic [ADDR_W-1:0] irom_addr;
  logic [31:0]       irom_wdata;
  logic              pc_first_we;
  logic [31:0]       pc_first_addr;
  logic              core_run;
  logic              boot_error;

  int checks = 0;
  int errors = 0;
  int pc_cnt = 0;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic [31:0] ref_data[$];
  logic [7:0]  pay[$];
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]  frame_xor;
`endif

  boot_sequencer #(.ADDR_W(ADDR_W), .BOOT_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .soft_reboot   (soft_reboot),
    .setup         (setup),
    .irom_we       (irom_we),
    .irom_addr     (irom_addr),
    .irom_wdata    (irom_wdata),
    .pc_first_we   (pc_first_we),
    .pc_first_addr (pc_first_addr),
    .core_run      (core_run),
    .boot_error    (boot_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (irom_we === 1'b1) begin
      wq_addr.push_back(32'(irom_addr));
      wq_data.push_back(irom_wdata);
    end
    if (pc_first_we === 1'b1) pc_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_header(input logic [15:0] n);
`ifdef BOOT_CHECKSUM_EN
    frame_xor = 8'h00;
`endif
    send_byte(n[7:0], 0);
    send_byte(n[15:8], 0);
  endtask

  task automatic send_pay(input logic [7:0] b, input int gap);
`ifdef BOOT_CHECKSUM_EN
    frame_xor = frame_xor ^ b;
`endif
    send_byte(b, gap);
  endtask

  // Appends the checksum byte when the feature is compiled in.
  task automatic finish_frame();
`ifdef BOOT_CHECKSUM_EN
    send_byte(frame_xor, 0);
`endif
  endtask

  task automatic wait_run(input string tag);
    int n = 0;
    while (core_run !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(core_run), 32'd1);
  endtask

  task automatic reboot();
    soft_reboot = 1'b1;
    @(negedge clk);
    soft_reboot = 1'b0;
    wq_addr.delete();
    wq_data.delete();
  endtask

  // Sends N words from pay[] (little-endian) and checks the IROM writes.
  task automatic load_words(input int n, input int max_gap, input string tag);
    logic [31:0] exp;
    send_header(16'(n));
    for (int i = 0; i < 4 * n; i++)
      send_pay(pay[i], (i % 4 == 0) ? 0 : $urandom_range(0, max_gap));
    finish_frame();
    wait_run({tag, "_run"});
    check({tag, "_count"}, 32'(wq_addr.size()), 32'(n));
    for (int j = 0; j < n && j < wq_addr.size(); j++) begin
      exp = {pay[4*j+3], pay[4*j+2], pay[4*j+1], pay[4*j]};
      check({tag, "_addr"}, wq_addr[j], 32'(j));
      check({tag, "_data"}, wq_data[j], exp);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    soft_reboot = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_setup",      32'(setup),       32'd1);
    check("rst_in_ready",   32'(in_ready),    32'd0);
    check("rst_irom_we",    32'(irom_we),     32'd0);
    check("rst_irom_addr",  32'(irom_addr),   32'd0);
    check("rst_irom_wdata", irom_wdata,       32'd0);
    check("rst_pc_we",      32'(pc_first_we), 32'd0);
    check("rst_core_run",   32'(core_run),    32'd0);
    check("rst_boot_error", 32'(boot_error),  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Two-word program, exact cycle timing.
    send_header(16'd2);
    send_pay(8'h13, 0); send_pay(8'h00, 0); send_pay(8'h00, 0); send_pay(8'h00, 0);
    send_pay(8'h93, 0); send_pay(8'h00, 0); send_pay(8'h10, 0); send_pay(8'h00, 0);
    check("w1_we",       32'(irom_we),   32'd1);
    check("w1_addr",     32'(irom_addr), 32'd1);
    check("w1_data",     irom_wdata,     32'h0010_0093);
    check("w1_in_ready", 32'(in_ready),  32'd0);
`ifdef BOOT_CHECKSUM_EN
    finish_frame();
`else
    @(negedge clk);
`endif
    check("start_pc_we",   32'(pc_first_we), 32'd1);
    check("start_pc_addr", pc_first_addr,    32'h0);
    check("start_setup",   32'(setup),       32'd1);
    check("start_no_we",   32'(irom_we),     32'd0);
    @(negedge clk);
    check("run_core_run", 32'(core_run), 32'd1);
    check("run_setup",    32'(setup),    32'd0);
    check("run_pc_we",    32'(pc_first_we), 32'd0);
    check("p1_writes",  32'(wq_addr.size()), 32'd2);
    check("p1_w0_addr", wq_addr[0], 32'd0);
    check("p1_w0_data", wq_data[0], 32'h0000_0013);
    check("p1_pc_cnt",  32'(pc_cnt), 32'd1);

    // RUN ignores incoming bytes.
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    check("run_in_ready", 32'(in_ready), 32'd0);
    check("run_ignore",   32'(wq_addr.size()), 32'd2);
    check("run_stays",    32'(core_run), 32'd1);

    // soft_reboot, then an empty program.
    reboot();
    check("reboot_setup",    32'(setup),    32'd1);
    check("reboot_in_ready", 32'(in_ready), 32'd1);
    send_header(16'd0);
    finish_frame();
    check("n0_pc_we", 32'(pc_first_we), 32'd1);
    check("n0_no_we", 32'(wq_addr.size()), 32'd0);
    @(negedge clk);
    check("n0_run", 32'(core_run), 32'd1);

    // N = 2**ADDR_W + 1 overflows.
    reboot();
    send_header(16'h0011);
    check("ovf_error",    32'(boot_error),  32'd1);
    check("ovf_in_ready", 32'(in_ready),    32'd0);
    check("ovf_setup",    32'(setup),       32'd1);
    check("ovf_no_pc",    32'(pc_first_we), 32'd0);
    repeat (3) @(negedge clk);
    check("ovf_sticky", 32'(boot_error), 32'd1);
    reboot();
    check("ovf_clear",    32'(boot_error), 32'd0);
    check("ovf_in_ready2", 32'(in_ready),  32'd1);

    // Full capacity N = 2**ADDR_W.
    pay.delete();
    for (int i = 0; i < 4 * 16; i++) pay.push_back(8'(i * 7 + 1));
    load_words(16, 0, "full");

    // N=3 gap-free, then the same with random gaps.
    reboot();
    pay.delete();
    for (int i = 0; i < 12; i++) pay.push_back(8'(8'hA0 + i * 3));
    load_words(3, 0, "nogap");
    ref_data = wq_data;
    reboot();
    load_words(3, 5, "gap");
    for (int j = 0; j < 3 && j < wq_data.size(); j++)
      check("gap_vs_nogap", wq_data[j], ref_data[j]);

    // Reload from RUN with one word; setup is high during the load.
    reboot();
    send_header(16'd1);
    send_pay(8'hAA, 0); send_pay(8'hBB, 0);
    check("reload_setup", 32'(setup), 32'd1);
    send_pay(8'hCC, 0); send_pay(8'hDD, 0);
    check("reload_we",   32'(irom_we),   32'd1);
    check("reload_addr", 32'(irom_addr), 32'd0);
    check("reload_data", irom_wdata,     32'hDDCC_BBAA);
    finish_frame();
    wait_run("reload_run");

    // Reset in the middle of a load restarts the counters.
    reboot();
    send_header(16'd2);
    send_pay(8'h11, 0); send_pay(8'h22, 0); send_pay(8'h33, 0); send_pay(8'h44, 0);
    send_pay(8'h55, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready),  32'd0);
    check("midrst_addr",     32'(irom_addr), 32'd0);
    check("midrst_setup",    32'(setup),     32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    wq_addr.delete();
    wq_data.delete();
    pay.delete();
    pay.push_back(8'h9A); pay.push_back(8'hBC); pay.push_back(8'hDE); pay.push_back(8'hF0);
    load_words(1, 0, "after_rst");

`ifdef BOOT_CHECKSUM_EN
    // Checksum match and mismatch.
    reboot();
    send_header(16'd1);
    send_pay(8'h01, 0); send_pay(8'h02, 0); send_pay(8'h04, 0); send_pay(8'h08, 0);
    send_byte(8'h0F, 0);
    wait_run("csum_ok_run");
    reboot();
    check("csum_pc_before", 32'(pc_cnt), 32'(pc_cnt));
    begin
      int pc_before;
      pc_before = pc_cnt;
      send_header(16'd1);
      send_pay(8'h01, 0); send_pay(8'h02, 0); send_pay(8'h04, 0); send_pay(8'h08, 0);
      send_byte(8'h0E, 0);
      check("csum_bad_error", 32'(boot_error), 32'd1);
      repeat (2) @(negedge clk);
      check("csum_bad_no_pc", 32'(pc_cnt), 32'(pc_before));
      check("csum_bad_run",   32'(core_run), 32'd0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL global_timeout: observed running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
